// File: rtl/sio_pkg.sv
// Shared definitions for the SIO frame layer: 40-bit frame field map, sync/CRC
// constants, link FSM states and the CRC-8 routine also used by the transmit framer.
package sio_pkg;

  localparam int SYNC_MSB = 39;
  localparam int SYNC_LSB = 36;
  localparam int ADDR_MSB = 35;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 8;
  localparam int CRC_MSB  = 7;
  localparam int CRC_LSB  = 0;

  localparam logic [3:0] SYNC_PATTERN = 4'b0101;
  localparam logic [7:0] CRC8_POLY    = 8'h07;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    RESYNC = 2'd2
  } state_e;

  // Bit-serial CRC-8, MSB first, init 0, no reflection, no final XOR.
  function automatic logic [7:0] crc8_32(input logic [31:0] msg);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[7] ^ msg[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
    return crc;
  endfunction

endpackage

// File: rtl/sio_crc_check.sv
// Combinational frame qualifier: sync nibble compare and CRC-8 check over the
// sync/addr/data fields against the trailing CRC byte.
module sio_crc_check
  import sio_pkg::*;
#(
  parameter int N = 40
) (
  input  logic [N-1:0] d_i,
  output logic         sync_ok_o,
  output logic         crc_ok_o
);

  assign sync_ok_o = (d_i[SYNC_MSB:SYNC_LSB] == SYNC_PATTERN);
  assign crc_ok_o  = (crc8_32(d_i[SYNC_MSB:DATA_LSB]) == d_i[CRC_MSB:CRC_LSB]);

endmodule

// File: rtl/sio_rx_frame.sv
// SIO receive frame layer: qualifies deserialized frames, runs the link lock FSM,
// forwards good frames while locked, counts errors and pulses resync on loss/silence.
module sio_rx_frame
  import sio_pkg::*;
#(
  parameter int N             = 40,
  parameter int LOCK_GOOD     = 4,
  parameter int LOSE_BAD      = 3,
  parameter int RESYNC_CYCLES = 16,
  parameter int TIMEOUT       = 1024
) (
  input  logic          c,
  input  logic          rn,
  input  logic [N-1:0]  d,
  input  logic          v,
  input  logic          err_clr,
  output logic [3:0]    q_addr,
  output logic [23:0]   q_data,
  output logic          q_v,
  output logic          locked,
  output logic [15:0]   err_count,
  output logic          resync
);

  localparam int CNT_W  = 4;
  localparam int RS_W   = (RESYNC_CYCLES > 2) ? $clog2(RESYNC_CYCLES) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  GOOD_LAST = CNT_W'(LOCK_GOOD - 1);
  localparam logic [CNT_W-1:0]  BAD_LAST  = CNT_W'(LOSE_BAD - 1);
  localparam logic [RS_W-1:0]   RS_LAST   = RS_W'(RESYNC_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  logic        sync_ok, crc_ok;
  logic        v_p1;
  logic        sync_ok_p1, crc_ok_p1;
  logic [3:0]  addr_p1;
  logic [23:0] data_p1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   good_q, good_d;
  logic [CNT_W-1:0]   bad_q, bad_d;
  logic [RS_W-1:0]    rs_q, rs_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [15:0]        err_q, err_d;
  logic               q_v_q;
  logic [3:0]         q_addr_q;
  logic [23:0]        q_data_q;
  logic               fwd, err_inc, go_rs, frame_good;

  sio_crc_check #(.N(N)) u_chk (
    .d_i       (d),
    .sync_ok_o (sync_ok),
    .crc_ok_o  (crc_ok)
  );

  // ---- stage 1: capture frame and qualifier flags (frames dropped during resync)
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      v_p1 <= 1'b0;
    end else begin
      v_p1 <= v & (state_q != RESYNC);
    end
  end

  always_ff @(posedge c) begin
    sync_ok_p1 <= sync_ok;
    crc_ok_p1  <= crc_ok;
    addr_p1    <= d[ADDR_MSB:ADDR_LSB];
    data_p1    <= d[DATA_MSB:DATA_LSB];
  end

  // ---- stage 2: link FSM, counters and forwarding
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    bad_d      = bad_q;
    rs_d       = rs_q;
    idle_d     = idle_q;
    fwd        = 1'b0;
    err_inc    = 1'b0;
    go_rs      = 1'b0;
    frame_good = sync_ok_p1 & crc_ok_p1;

    case (state_q)
      HUNT, LOCKED: begin
        // Silence timeout outranks any frame presented in the same cycle.
        if (idle_q == IDLE_MAX) begin
          go_rs   = 1'b1;
          err_inc = (state_q == LOCKED);
        end else begin
          idle_d = v_p1 ? '0 : idle_q + 1'b1;
          if (v_p1) begin
            if (state_q == HUNT) begin
              if (!frame_good) begin
                good_d = '0;
              end else if (good_q == GOOD_LAST) begin
                state_d = LOCKED;
                good_d  = '0;
              end else begin
                good_d = good_q + 1'b1;
              end
            end else if (frame_good) begin
              fwd   = 1'b1;
              bad_d = '0;
            end else begin
              err_inc = 1'b1;
              if (bad_q == BAD_LAST) go_rs = 1'b1;
              else                   bad_d = bad_q + 1'b1;
            end
          end
        end
      end
      RESYNC: begin
        if (rs_q == RS_LAST) begin
          state_d = HUNT;
          rs_d    = '0;
        end else begin
          rs_d = rs_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    if (go_rs) begin
      state_d = RESYNC;
      good_d  = '0;
      bad_d   = '0;
      rs_d    = '0;
      idle_d  = '0;
    end

    if (err_clr)                          err_d = 16'h0000;
    else if (err_inc && err_q != 16'hFFFF) err_d = err_q + 1'b1;
    else                                  err_d = err_q;
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_q  <= HUNT;
      good_q   <= '0;
      bad_q    <= '0;
      rs_q     <= '0;
      idle_q   <= '0;
      err_q    <= '0;
      q_v_q    <= 1'b0;
      q_addr_q <= '0;
      q_data_q <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      rs_q    <= rs_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      q_v_q   <= fwd;
      if (fwd) begin
        q_addr_q <= addr_p1;
        q_data_q <= data_p1;
      end
    end
  end

  assign q_v       = q_v_q;
  assign q_addr    = q_addr_q;
  assign q_data    = q_data_q;
  assign err_count = err_q;
  assign locked    = (state_q == LOCKED);
  assign resync    = (state_q == RESYNC);

endmodule

// File: tb/tb_sio_rx_frame.sv
// Bench for sio_rx_frame: directed frame sequences, a frame-level reference model
// checked every cycle, and hand-computed literal expectations.
module tb_sio_rx_frame;

  localparam int N             = 40;
  localparam int LOCK_GOOD     = 4;
  localparam int LOSE_BAD      = 3;
  localparam int RESYNC_CYCLES = 16;
  localparam int TIMEOUT       = 1024;

  localparam int M_HUNT = 0;
  localparam int M_LOCK = 1;
  localparam int M_RS   = 2;

  logic          c = 1'b0;
  logic          rn = 1'b0;
  logic [N-1:0]  d = '0;
  logic          v = 1'b0;
  logic          err_clr = 1'b0;
  logic [3:0]    q_addr;
  logic [23:0]   q_data;
  logic          q_v, locked, resync;
  logic [15:0]   err_count;

  int total = 0;
  int bad   = 0;

  sio_rx_frame #(
    .N(N), .LOCK_GOOD(LOCK_GOOD), .LOSE_BAD(LOSE_BAD),
    .RESYNC_CYCLES(RESYNC_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .c(c), .rn(rn), .d(d), .v(v), .err_clr(err_clr),
    .q_addr(q_addr), .q_data(q_data), .q_v(q_v),
    .locked(locked), .err_count(err_count), .resync(resync)
  );

  always #5 c = ~c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-at-a-time CRC-8 (poly 0x07), independent of the RTL's bit-serial form.
  function automatic logic [7:0] ref_crc(input logic [31:0] m);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 3; b >= 0; b--) begin
      r = r ^ m[b*8 +: 8];
      for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  function automatic logic [39:0] mk(input logic [3:0] s, input logic [3:0] a, input logic [23:0] dt);
    logic [31:0] h;
    h = {s, a, dt};
    return {h, ref_crc(h)};
  endfunction

  // ---------------- reference model ----------------
  int          m_mode = M_HUNT;
  int          m_good = 0, m_bad = 0, m_idle = 0, m_rs = 0, m_err = 0;
  logic        m_qv = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [23:0] m_data = '0;
  logic        pend_v = 1'b0, pend_good = 1'b0;
  logic [3:0]  pend_addr = '0;
  logic [23:0] pend_data = '0;
  logic        nv, ngood;
  logic [3:0]  naddr;
  logic [23:0] ndata;

  task automatic m_enter_resync();
    m_mode = M_RS; m_rs = 0; m_good = 0; m_bad = 0; m_idle = 0;
  endtask

  task automatic m_bump();
    if (m_err < 65535) m_err++;
  endtask

  always @(posedge c or negedge rn) begin
    if (!rn) begin
      m_mode = M_HUNT; m_good = 0; m_bad = 0; m_idle = 0; m_rs = 0; m_err = 0;
      m_qv = 1'b0; m_addr = '0; m_data = '0; pend_v = 1'b0;
    end else begin
      nv    = v && (m_mode != M_RS);
      ngood = (d[39:36] == 4'b0101) && (ref_crc(d[39:8]) == d[7:0]);
      naddr = d[35:32];
      ndata = d[31:8];
      m_qv  = 1'b0;
      if (m_mode == M_RS) begin
        m_rs++;
        if (m_rs == RESYNC_CYCLES) m_mode = M_HUNT;
      end else if (m_idle == TIMEOUT) begin
        if (m_mode == M_LOCK) m_bump();
        m_enter_resync();
      end else begin
        m_idle = pend_v ? 0 : m_idle + 1;
        if (pend_v && m_mode == M_HUNT) begin
          if (pend_good) begin
            m_good++;
            if (m_good == LOCK_GOOD) begin m_mode = M_LOCK; m_good = 0; end
          end else m_good = 0;
        end else if (pend_v) begin
          if (pend_good) begin
            m_qv = 1'b1; m_addr = pend_addr; m_data = pend_data; m_bad = 0;
          end else begin
            m_bump();
            m_bad++;
            if (m_bad == LOSE_BAD) m_enter_resync();
          end
        end
      end
      if (err_clr) m_err = 0;
      pend_v = nv; pend_good = ngood; pend_addr = naddr; pend_data = ndata;
    end
  end

  always @(negedge c) begin
    chk("q_v",       64'(q_v),       64'(m_qv));
    chk("locked",    64'(locked),    64'(m_mode == M_LOCK));
    chk("resync",    64'(resync),    64'(m_mode == M_RS));
    chk("err_count", 64'(err_count), 64'(m_err));
    chk("q_addr",    64'(q_addr),    64'(m_addr));
    chk("q_data",    64'(q_data),    64'(m_data));
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge c); #2; end
  endtask

  task automatic send(input logic [39:0] f);
    d = f; v = 1'b1;
    @(posedge c); #2;
    v = 1'b0;
  endtask

  logic [39:0] g_frame, f;
  int n;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1);
  end

  initial begin
    g_frame = mk(4'b0101, 4'd3, 24'hABCDEF);
    chk("crc_literal",   64'(ref_crc(32'h53ABCDEF)), 64'h00E5);
    chk("frame_literal", 64'(g_frame), 64'h53ABCDEFE5);

    repeat (3) @(posedge c);
    #2;
    chk("rst_q_v",    64'(q_v), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_resync", 64'(resync), 64'd0);
    chk("rst_err",    64'(err_count), 64'd0);
    chk("rst_data",   64'({q_addr, q_data}), 64'd0);
    rn = 1'b1;
    wait_cyc(3);

    // 1: four goods lock without forwarding; fifth is forwarded
    for (int i = 0; i < 4; i++) begin
      send(g_frame);
      chk("t1_not_yet_locked", 64'(locked), 64'd0);
      if (i < 3) wait_cyc(39);
    end
    wait_cyc(1);
    chk("t1_locked", 64'(locked), 64'd1);
    wait_cyc(38);
    send(g_frame);
    chk("t1_no_early_qv", 64'(q_v), 64'd0);
    wait_cyc(1);
    chk("t1_qv", 64'(q_v), 64'd1);
    chk("t1_addr", 64'(q_addr), 64'd3);
    chk("t1_data", 64'(q_data), 64'hABCDEF);

    // 2: two bad CRCs, a good, back-to-back goods, then three bads force resync
    wait_cyc(10); send(g_frame ^ 40'h1);
    wait_cyc(10); send(g_frame ^ 40'h80);
    wait_cyc(10); send(mk(4'b0101, 4'd7, 24'h123456));
    wait_cyc(1);
    chk("t2_qv",     64'(q_v), 64'd1);
    chk("t2_addr",   64'(q_addr), 64'd7);
    chk("t2_data",   64'(q_data), 64'h123456);
    chk("t2_err2",   64'(err_count), 64'd2);
    chk("t2_locked", 64'(locked), 64'd1);
    wait_cyc(5);
    send(mk(4'b0101, 4'd1, 24'h111111));
    send(mk(4'b0101, 4'd2, 24'h222222));
    wait_cyc(5);
    chk("t2_b2b_addr", 64'(q_addr), 64'd2);
    chk("t2_b2b_data", 64'(q_data), 64'h222222);
    send(g_frame ^ 40'h1);
    send(g_frame ^ 40'h2);
    send(g_frame ^ 40'h4);
    wait_cyc(1);
    chk("t2_err5",      64'(err_count), 64'd5);
    chk("t2_unlocked",  64'(locked), 64'd0);
    chk("t2_resync_on", 64'(resync), 64'd1);
    n = 0;
    while (resync && n < 40) begin n++; wait_cyc(1); end
    chk("t2_resync_len", 64'(n), 64'd16);
    chk("t2_hunt_locked", 64'(locked), 64'd0);

    // 3: good, good, bad sync, good x4 -> lock only after the last four
    wait_cyc(5);
    for (int i = 0; i < 7; i++) begin
      f = (i == 2) ? mk(4'b1111, 4'd3, 24'hABCDEF) : g_frame;
      send(f);
      wait_cyc(1);
      chk("t3_lock_seq", 64'(locked), 64'(i == 6));
      if (i < 6) wait_cyc(8);
    end

    // 4: silence while locked -> timeout resync; frames during resync ignored
    n = 0;
    while (!resync && n < 2000) begin wait_cyc(1); n++; end
    chk("t4_timeout_cycles", 64'(n), 64'd1025);
    chk("t4_err6",   64'(err_count), 64'd6);
    chk("t4_locked", 64'(locked), 64'd0);
    send(g_frame);
    wait_cyc(2);
    send(g_frame);
    wait_cyc(30);
    chk("t4_resync_off", 64'(resync), 64'd0);
    for (int i = 0; i < 3; i++) begin send(g_frame); wait_cyc(3); end
    chk("t4_ignored_frames", 64'(locked), 64'd0);
    send(g_frame);
    wait_cyc(1);
    chk("t4_relock", 64'(locked), 64'd1);

    // 5: saturation and err_clr priority
    force dut.err_q = 16'hFFFF;
    m_err = 65535;
    wait_cyc(1);
    release dut.err_q;
    wait_cyc(1);
    chk("t5_preload", 64'(err_count), 64'hFFFF);
    send(g_frame ^ 40'h1);
    wait_cyc(1);
    chk("t5_saturate", 64'(err_count), 64'hFFFF);
    send(g_frame ^ 40'h1);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    chk("t5_clr_wins", 64'(err_count), 64'd0);
    send(g_frame);
    send(g_frame ^ 40'h1);
    wait_cyc(1);
    chk("t5_count_after_clr", 64'(err_count), 64'd1);
    chk("t5_still_locked", 64'(locked), 64'd1);

    // 6: async reset in the middle of a resync window
    send(g_frame ^ 40'h1);
    send(g_frame ^ 40'h1);
    wait_cyc(5);
    chk("t6_in_resync", 64'(resync), 64'd1);
    rn = 1'b0;
    #1;
    chk("t6_async_resync", 64'(resync), 64'd0);
    wait_cyc(2);
    chk("t6_rst_locked", 64'(locked), 64'd0);
    chk("t6_rst_err",    64'(err_count), 64'd0);
    chk("t6_rst_qv",     64'(q_v), 64'd0);
    chk("t6_rst_data",   64'({q_addr, q_data}), 64'd0);
    rn = 1'b1;
    wait_cyc(100);
    chk("t6_no_resync", 64'(resync), 64'd0);
    chk("t6_hunt",      64'(locked), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
